// File: rtl/mastermind_board_if.sv
// Bus between the game core and the guess board: cell writes, score handshake,
// and the packed board/feedback views consumed by the renderer.
interface mastermind_board_if #(
  parameter int NUM_PEGS    = 4,
  parameter int COLOR_W     = 3,
  parameter int MAX_GUESSES = 6
);
  localparam int ROW_W = $clog2(MAX_GUESSES + 1);
  localparam int PEG_W = $clog2(NUM_PEGS);

  logic                                  wr_en;
  logic [ROW_W-1:0]                      guess_row;
  logic [PEG_W-1:0]                      index;
  logic [COLOR_W-1:0]                    color;
  logic                                  score_start;
  logic [NUM_PEGS*COLOR_W-1:0]           correct_answer;
  logic [MAX_GUESSES*NUM_PEGS*COLOR_W-1:0] matrix_flat;
  logic [MAX_GUESSES*NUM_PEGS*2-1:0]     feedback_flat;
  logic                                  score_busy;
  logic                                  score_done;
  logic                                  all_correct;
  logic [MAX_GUESSES-1:0]                scored_rows;

  modport master (
    output wr_en, guess_row, index, color, score_start, correct_answer,
    input  matrix_flat, feedback_flat, score_busy, score_done, all_correct, scored_rows
  );

  modport slave (
    input  wr_en, guess_row, index, color, score_start, correct_answer,
    output matrix_flat, feedback_flat, score_busy, score_done, all_correct, scored_rows
  );
endinterface

// File: rtl/mastermind_board.sv
// Guess-board store plus a sequential Wordle-style scorer: exact matches in one
// cycle, then one peg per cycle for present/absent with per-position consumption.
module mastermind_board #(
  parameter int NUM_PEGS    = 4,
  parameter int COLOR_W     = 3,
  parameter int MAX_GUESSES = 6
) (
  input logic               Clk,
  input logic               Reset,
  mastermind_board_if.slave bus
);
  localparam int ROW_W    = $clog2(MAX_GUESSES + 1);
  localparam int PEG_W    = $clog2(NUM_PEGS);
  localparam int ROW_BITS = NUM_PEGS * COLOR_W;
  localparam int FB_ROW   = NUM_PEGS * 2;
  localparam int MAT_BITS = MAX_GUESSES * ROW_BITS;
  localparam int FB_BITS  = MAX_GUESSES * FB_ROW;
  localparam int MAT_IW   = $clog2(MAT_BITS);
  localparam int FB_IW    = $clog2(FB_BITS);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] EXACT   = 3'd2;
  localparam logic [2:0] PARTIAL = 3'd3;
  localparam logic [2:0] WRITE   = 3'd4;

  logic [2:0]             state;
  logic [MAT_BITS-1:0]    matrix_q;
  logic [FB_BITS-1:0]     feedback_q;
  logic [MAX_GUESSES-1:0] scored_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   all_correct_q;
  logic [ROW_W-1:0]       row_q;
  logic [PEG_W-1:0]       peg_q;
  logic [COLOR_W-1:0]     guess_q [NUM_PEGS];
  logic [COLOR_W-1:0]     ans_q   [NUM_PEGS];
  logic [1:0]             fb_q    [NUM_PEGS];
  logic [NUM_PEGS-1:0]    used_q;

  logic                   row_ok;
  logic [MAT_IW-1:0]      wr_base;
  logic [MAT_IW-1:0]      rd_base;
  logic [FB_IW-1:0]       fb_base;
  logic [ROW_BITS-1:0]    row_slice;
  logic [FB_ROW-1:0]      fb_packed;
  logic                   all_exact;
  logic                   hit;
  logic [PEG_W-1:0]       hit_idx;
  logic [COLOR_W-1:0]     cur_guess;

  always_comb begin
    row_ok    = bus.guess_row < ROW_W'(MAX_GUESSES);
    wr_base   = MAT_IW'(int'(bus.guess_row) * ROW_BITS + int'(bus.index) * COLOR_W);
    rd_base   = MAT_IW'(int'(row_q) * ROW_BITS);
    fb_base   = FB_IW'(int'(row_q) * FB_ROW);
    row_slice = matrix_q[rd_base +: ROW_BITS];
    fb_packed = '0;
    all_exact = 1'b1;
    for (int unsigned i = 0; i < NUM_PEGS; i++) begin
      fb_packed[i*2 +: 2] = fb_q[i];
      if (fb_q[i] != 2'b11) all_exact = 1'b0;
    end
  end

  // First unused answer position with the same colour claims the current peg.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    cur_guess = guess_q[peg_q];
    for (int unsigned j = 0; j < NUM_PEGS; j++) begin
      if (!hit && !used_q[j] && cur_guess != '0 && ans_q[j] == cur_guess) begin
        hit     = 1'b1;
        hit_idx = PEG_W'(j);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      matrix_q      <= '0;
      feedback_q    <= '0;
      scored_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      all_correct_q <= 1'b0;
      row_q         <= '0;
      peg_q         <= '0;
      used_q        <= '0;
      for (int unsigned i = 0; i < NUM_PEGS; i++) begin
        guess_q[i] <= '0;
        ans_q[i]   <= '0;
        fb_q[i]    <= '0;
      end
    end else begin
      done_q        <= 1'b0;
      all_correct_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.wr_en && row_ok) matrix_q[wr_base +: COLOR_W] <= bus.color;
          if (bus.score_start && row_ok) begin
            row_q  <= bus.guess_row;
            busy_q <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          for (int unsigned i = 0; i < NUM_PEGS; i++) begin
            guess_q[i] <= row_slice[i*COLOR_W +: COLOR_W];
            ans_q[i]   <= bus.correct_answer[i*COLOR_W +: COLOR_W];
          end
          state <= EXACT;
        end
        EXACT: begin
          for (int unsigned i = 0; i < NUM_PEGS; i++) begin
            if (guess_q[i] != '0 && guess_q[i] == ans_q[i]) begin
              fb_q[i]   <= 2'b11;
              used_q[i] <= 1'b1;
            end else begin
              fb_q[i]   <= 2'b00;
              used_q[i] <= 1'b0;
            end
          end
          peg_q <= '0;
          state <= PARTIAL;
        end
        PARTIAL: begin
          if (fb_q[peg_q] != 2'b11) begin
            if (hit) begin
              fb_q[peg_q]     <= 2'b10;
              used_q[hit_idx] <= 1'b1;
            end else begin
              fb_q[peg_q] <= 2'b01;
            end
          end
          if (peg_q == PEG_W'(NUM_PEGS - 1)) state <= WRITE;
          else peg_q <= peg_q + 1'b1;
        end
        WRITE: begin
          feedback_q[fb_base +: FB_ROW] <= fb_packed;
          scored_q[row_q]               <= 1'b1;
          done_q                        <= 1'b1;
          all_correct_q                 <= all_exact;
          busy_q                        <= 1'b0;
          state                         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.matrix_flat   = matrix_q;
  assign bus.feedback_flat = feedback_q;
  assign bus.scored_rows   = scored_q;
  assign bus.score_busy    = busy_q;
  assign bus.score_done    = done_q;
  assign bus.all_correct   = all_correct_q;
endmodule

// File: tb/tb_mastermind_board.sv
// Directed bench for mastermind_board: writes, scoring latency, duplicates,
// empty pegs, busy-time rejection and mid-score reset.
module tb_mastermind_board;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mastermind_board_if bus ();

  mastermind_board dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cell(input logic [2:0] row, input logic [1:0] idx, input logic [2:0] col);
    bus.wr_en     = 1'b1;
    bus.guess_row = row;
    bus.index     = idx;
    bus.color     = col;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic start_score(input logic [2:0] row);
    bus.guess_row   = row;
    bus.score_start = 1'b1;
    tick();
    bus.score_start = 1'b0;
  endtask

  // Walks cycles 1..7 checking busy, ends sampling cycle 8.
  task automatic run_to_done(input string name);
    int bad;
    bad = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (bus.score_busy !== 1'b1 || bus.score_done !== 1'b0) bad++;
      tick();
    end
    @(negedge clk);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s busy_window bad_cycles=%0d want 0", name, bad);
    end
    checks++;
    if (bus.score_done !== 1'b1 || bus.score_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle8 done=%b busy=%b want done=1 busy=0", name, bus.score_done, bus.score_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.matrix_flat !== '0 || bus.feedback_flat !== '0 || bus.scored_rows !== '0 ||
        bus.score_busy !== 1'b0 || bus.score_done !== 1'b0 || bus.all_correct !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs matrix=%h fb=%h scored=%b busy=%b done=%b ac=%b want all 0",
               bus.matrix_flat, bus.feedback_flat, bus.scored_rows, bus.score_busy, bus.score_done, bus.all_correct);
    end
    tick();
    write_cell(3'd0, 2'd0, 3'd1);
    write_cell(3'd0, 2'd1, 3'd2);
    write_cell(3'd0, 2'd2, 3'd3);
    write_cell(3'd0, 2'd3, 3'd4);
    @(negedge clk);
    checks++;
    if (bus.matrix_flat !== 72'h8D1) begin
      errors++;
      $display("FAIL write_row0 matrix=%h want %h", bus.matrix_flat, 72'h8D1);
    end
  endtask

  task automatic test_score_basic();
    bus.correct_answer = {3'd1, 3'd1, 3'd1, 3'd1};
    tick();
    start_score(3'd0);
    run_to_done("basic");
    checks++;
    if (bus.feedback_flat[7:0] !== 8'b01_01_01_11 || bus.all_correct !== 1'b0) begin
      errors++;
      $display("FAIL basic_feedback fb=%b ac=%b want 01010111 ac=0", bus.feedback_flat[7:0], bus.all_correct);
    end
    checks++;
    if (bus.scored_rows !== 6'b000001) begin
      errors++;
      $display("FAIL basic_scored scored=%b want 000001", bus.scored_rows);
    end
    tick();
  endtask

  task automatic test_duplicates();
    write_cell(3'd1, 2'd0, 3'd2);
    write_cell(3'd1, 2'd1, 3'd2);
    write_cell(3'd1, 2'd2, 3'd1);
    write_cell(3'd1, 2'd3, 3'd1);
    bus.correct_answer = {3'd4, 3'd3, 3'd2, 3'd1};
    tick();
    start_score(3'd1);
    tick();
    bus.correct_answer = {3'd2, 3'd2, 3'd2, 3'd2};  // latched answer must be used
    @(negedge clk);
    for (int c = 2; c <= 7; c++) tick();
    @(negedge clk);
    checks++;
    if (bus.score_done !== 1'b1) begin
      errors++;
      $display("FAIL dup_done done=%b want 1", bus.score_done);
    end
    checks++;
    if (bus.feedback_flat[15:0] !== {8'b01_10_11_01, 8'b01_01_01_11}) begin
      errors++;
      $display("FAIL dup_feedback fb=%b want 0110110101010111", bus.feedback_flat[15:0]);
    end
    bus.correct_answer = {3'd4, 3'd3, 3'd2, 3'd1};
    tick();
  endtask

  task automatic test_all_correct();
    write_cell(3'd2, 2'd0, 3'd1);
    write_cell(3'd2, 2'd1, 3'd2);
    write_cell(3'd2, 2'd2, 3'd3);
    write_cell(3'd2, 2'd3, 3'd4);
    start_score(3'd2);
    run_to_done("allc");
    checks++;
    if (bus.feedback_flat[23:16] !== 8'hFF || bus.all_correct !== 1'b1 || bus.scored_rows !== 6'b000111) begin
      errors++;
      $display("FAIL allc_done fb=%h ac=%b scored=%b want FF 1 000111",
               bus.feedback_flat[23:16], bus.all_correct, bus.scored_rows);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.all_correct !== 1'b0 || bus.score_done !== 1'b0) begin
      errors++;
      $display("FAIL allc_after ac=%b done=%b want 0 0", bus.all_correct, bus.score_done);
    end
  endtask

  task automatic test_empty_peg();
    bus.correct_answer = {3'd3, 3'd2, 3'd1, 3'd0};
    tick();
    start_score(3'd3);
    run_to_done("empty");
    checks++;
    if (bus.feedback_flat[31:24] !== 8'h55 || bus.all_correct !== 1'b0) begin
      errors++;
      $display("FAIL empty_feedback fb=%b ac=%b want 01010101 0", bus.feedback_flat[31:24], bus.all_correct);
    end
    tick();
    bus.correct_answer = {3'd4, 3'd3, 3'd2, 3'd1};
    bus.wr_en       = 1'b1;
    bus.index       = 2'd0;
    bus.color       = 3'd1;
    start_score(3'd4);
    bus.wr_en = 1'b0;
    run_to_done("samecyc");
    checks++;
    if (bus.feedback_flat[39:32] !== 8'b01_01_01_11) begin
      errors++;
      $display("FAIL samecyc_feedback fb=%b want 01010111", bus.feedback_flat[39:32]);
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    logic [71:0] exp_mat;
    logic [47:0] exp_fb;
    int dones;
    int busy_seen;
    exp_mat = {12'h000, 12'h001, 12'h000, 12'h8D1, 12'h252, 12'h8D1};
    exp_fb  = {8'h00, 8'h57, 8'h55, 8'hFF, 8'h6D, 8'h57};
    dones = 0;
    start_score(3'd2);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.score_done === 1'b1) dones++;
      if (c == 2) begin
        bus.wr_en       = 1'b1;
        bus.guess_row   = 3'd0;
        bus.index       = 2'd0;
        bus.color       = 3'd7;
        bus.score_start = 1'b1;
      end
      tick();
      bus.wr_en       = 1'b0;
      bus.score_start = 1'b0;
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL busy_done_count got %0d want 1", dones);
    end
    checks++;
    if (bus.matrix_flat !== exp_mat || bus.feedback_flat !== exp_fb) begin
      errors++;
      $display("FAIL busy_state matrix=%h fb=%h want %h %h", bus.matrix_flat, bus.feedback_flat, exp_mat, exp_fb);
    end
    busy_seen = 0;
    bus.guess_row   = 3'd6;
    bus.score_start = 1'b1;
    bus.wr_en       = 1'b1;
    bus.color       = 3'd5;
    tick();
    bus.score_start = 1'b0;
    bus.wr_en       = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.score_busy !== 1'b0 || bus.score_done !== 1'b0) busy_seen++;
      tick();
    end
    checks++;
    if (busy_seen != 0 || bus.matrix_flat !== exp_mat) begin
      errors++;
      $display("FAIL row6_ignored bad_cycles=%0d matrix=%h want 0 %h", busy_seen, bus.matrix_flat, exp_mat);
    end
  endtask

  task automatic test_rewrite();
    write_cell(3'd0, 2'd0, 3'd4);
    @(negedge clk);
    checks++;
    if (bus.matrix_flat[11:0] !== 12'h8D4 || bus.feedback_flat[7:0] !== 8'h57 || bus.scored_rows !== 6'b011111) begin
      errors++;
      $display("FAIL rewrite row0=%h fb0=%h scored=%b want 8d4 57 011111",
               bus.matrix_flat[11:0], bus.feedback_flat[7:0], bus.scored_rows);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    start_score(3'd1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (bus.matrix_flat !== '0 || bus.feedback_flat !== '0 || bus.scored_rows !== '0 ||
        bus.score_busy !== 1'b0 || bus.score_done !== 1'b0 || bus.all_correct !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs matrix=%h fb=%h scored=%b busy=%b done=%b want all 0",
               bus.matrix_flat, bus.feedback_flat, bus.scored_rows, bus.score_busy, bus.score_done);
    end
    rst = 1'b0;
    tick();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.score_done !== 1'b0 || bus.score_busy !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset_no_done bad_cycles=%0d want 0", bad);
    end
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    rst                = 1'b1;
    bus.wr_en          = 1'b0;
    bus.guess_row      = '0;
    bus.index          = '0;
    bus.color          = '0;
    bus.score_start    = 1'b0;
    bus.correct_answer = '0;
    test_reset();
    test_score_basic();
    test_duplicates();
    test_all_correct();
    test_empty_peg();
    test_busy_ignore();
    test_rewrite();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
